ubi_stream_decode: RTL

- Bipolar unary-to-binary decoder; the receive end of the bitstreams produced by the bipolar unary multiplier and Sobol stream generators in the SFFT datapath.
- Counts ones in a stream over a fixed window of 2^BITWIDTH enabled cycles.
- Returns the offset-binary code, the same encoding used for the multiplier's iB input, with a one-cycle valid pulse.
- Sits at the SFFT output stage and in benches as the stream-to-value checker.

---
 rtl/ubi_stream_decode_if.sv | 24 ++
 rtl/ubi_stream_decode.sv | 100 ++++++++++
 2 files changed

// File: rtl/ubi_stream_decode_if.sv
// Stream/result bundle for ubi_stream_decode.
// master: stream source / result consumer; slave: the decoder.
// BITWIDTH must match the decoder's BITWIDTH.
interface ubi_stream_decode_if #(
  parameter int BITWIDTH = 8
);
  logic                iEn;
  logic                iClr;
  logic                iStart;
  logic                iBit;
  logic [BITWIDTH-1:0] oBin;
  logic                oValid;
  logic                oBusy;

  modport master (
    output iEn, iClr, iStart, iBit,
    input  oBin, oValid, oBusy
  );

  modport slave (
    input  iEn, iClr, iStart, iBit,
    output oBin, oValid, oBusy
  );
endinterface

// File: rtl/ubi_stream_decode.sv
// Bipolar unary-to-binary decoder: counts ones over a window of
// 2^BITWIDTH enabled samples and reports the saturated count as an
// offset-binary code with a one-cycle valid pulse.
// Build option UBI_DECODE_SIGNED_EN: result registered in two's
// complement (offset-binary with MSB inverted); timing is unchanged.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | no window open; waiting for iStart & iEn
// ST_ACCUM | window open; each enabled edge takes one sample of iBit
module ubi_stream_decode #(
  parameter int BITWIDTH = 8
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  ubi_stream_decode_if.slave    bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam logic [BITWIDTH-1:0] LAST_SMP = '1;

  state_t              r_state, w_state_nxt;
  logic [BITWIDTH-1:0] r_smp_cnt, w_smp_cnt_nxt;
  logic [BITWIDTH:0]   r_ones, w_ones_nxt;
  logic [BITWIDTH-1:0] r_bin, w_bin_nxt;
  logic                r_valid, w_valid_nxt;

  logic [BITWIDTH:0]   w_final;
  logic [BITWIDTH-1:0] w_sat;
  logic [BITWIDTH-1:0] w_code;

  // Final count includes the sample captured on the completing edge;
  // a full window of ones (N) cannot be represented, so clamp to N-1.
  assign w_final = r_ones + {{BITWIDTH{1'b0}}, bus.iBit};
  assign w_sat   = w_final[BITWIDTH] ? '1 : w_final[BITWIDTH-1:0];

`ifdef UBI_DECODE_SIGNED_EN
  assign w_code = {~w_sat[BITWIDTH-1], w_sat[BITWIDTH-2:0]};
`else
  assign w_code = w_sat;
`endif

  // State and datapath registers.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state   <= ST_IDLE;
      r_smp_cnt <= '0;
      r_ones    <= '0;
      r_bin     <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_smp_cnt <= w_smp_cnt_nxt;
      r_ones    <= w_ones_nxt;
      r_bin     <= w_bin_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  // Next state: clear beats start, start beats sampling (a start inside
  // a window, even on its last sample, restarts and suppresses oValid).
  always_comb begin
    w_state_nxt   = r_state;
    w_smp_cnt_nxt = r_smp_cnt;
    w_ones_nxt    = r_ones;
    w_bin_nxt     = r_bin;
    w_valid_nxt   = 1'b0;

    if (bus.iClr) begin
      w_state_nxt   = ST_IDLE;
      w_smp_cnt_nxt = '0;
      w_ones_nxt    = '0;
      w_bin_nxt     = '0;
    end else if (bus.iStart && bus.iEn) begin
      w_state_nxt   = ST_ACCUM;
      w_smp_cnt_nxt = '0;
      w_ones_nxt    = '0;
    end else if (r_state == ST_ACCUM && bus.iEn) begin
      if (r_smp_cnt == LAST_SMP) begin
        w_state_nxt   = ST_IDLE;
        w_smp_cnt_nxt = '0;
        w_ones_nxt    = '0;
        w_bin_nxt     = w_code;
        w_valid_nxt   = 1'b1;
      end else begin
        w_smp_cnt_nxt = r_smp_cnt + 1'b1;
        w_ones_nxt    = w_final;
      end
    end
  end

  assign bus.oBin   = r_bin;
  assign bus.oValid = r_valid;
  assign bus.oBusy  = (r_state == ST_ACCUM);

endmodule
